// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response handshake and word-memory port of the load/store unit.
// slave = the LSU itself; master = the core plus data memory around it.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_w_en;
    logic        mem_read_en;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_w_en, mem_read_en
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_w_en, mem_read_en
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit in front of a word-wide data memory; sub-word stores use a 2-cycle RMW.
// Optional macro LSU_BOUNDS_CHECK_EN: byte addresses beyond DEPTH words are reported as errors.
module lsu_ctrl #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx_q;
    logic [31:0]   merge_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    logic [AW-1:0] req_idx;
    logic          ready, accept;
    logic          is_half, is_word, subword_st;
    logic          invalid, misaligned, out_of_range, req_err;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_data, merged;

    assign req_idx    = bus.req_addr[AW+1:2];
    assign is_half    = (bus.req_funct3[1:0] == 2'b01);
    assign is_word    = (bus.req_funct3[1:0] == 2'b10);
    assign subword_st = bus.req_we & ~is_word;

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = |bus.req_addr[31:AW+2];
`else
    logic addr_hi_unused;
    assign addr_hi_unused = |bus.req_addr[31:AW+2];
    assign out_of_range   = 1'b0;
`endif

    assign invalid = bus.req_we ? (bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11))
                                : ((bus.req_funct3[1:0] == 2'b11) | (bus.req_funct3[2:1] == 2'b11));
    assign misaligned = (is_half & bus.req_addr[0]) | (is_word & (|bus.req_addr[1:0]));
    assign req_err    = invalid | misaligned | out_of_range;

    assign ready  = (state == IDLE) & ~rst;
    assign accept = bus.req_valid & ready;

    always_comb begin
        lane_b = bus.mem_rdata[{bus.req_addr[1:0], 3'b000} +: 8];
        lane_h = bus.req_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (bus.req_funct3)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {24'h0, lane_b};
            3'b101:  load_data = {16'h0, lane_h};
            default: load_data = bus.mem_rdata;
        endcase
        // Only the addressed lane is replaced; the rest of the word comes from the current read.
        merged = bus.mem_rdata;
        if (is_half) merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
        else         merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
    end

    always_comb begin
        state_nxt       = state;
        bus.mem_addr    = {{(32-AW){1'b0}}, req_idx};
        bus.mem_wdata   = bus.req_wdata;
        bus.mem_w_en    = 1'b0;
        bus.mem_read_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && !req_err) begin
                    bus.mem_read_en = ~bus.req_we | subword_st;
                    bus.mem_w_en    = bus.req_we & is_word;
                    if (subword_st) state_nxt = RMW_WR;
                end
            end
            RMW_WR: begin
                bus.mem_addr  = {{(32-AW){1'b0}}, idx_q};
                bus.mem_wdata = merge_q;
                bus.mem_w_en  = ~rst;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            idx_q       <= '0;
            merge_q     <= '0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= 1'b0;
            if (state == RMW_WR) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end else if (accept) begin
                if (subword_st && !req_err) begin
                    idx_q   <= req_idx;
                    merge_q <= merged;
                end else begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= req_err;
                    rsp_rdata_q <= (req_err || bus.req_we) ? '0 : load_data;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
